// File: rtl/hazard_unit_pkg.sv
// Shared opcode encoding, decode classes and scoreboard entry type
// for the ID-stage hazard unit.
`ifndef OP_CODE_LEN
`define OP_CODE_LEN 4
`define OP_NOP  4'h0
`define OP_ADD  4'h1
`define OP_SUB  4'h2
`define OP_MUL  4'h3
`define OP_DIV  4'h4
`define OP_MOD  4'h5
`define OP_AND  4'h6
`define OP_OR   4'h7
`define OP_CMP  4'h8
`define OP_MOVR 4'h9
`define OP_MOVI 4'hA
`define OP_LDR  4'hB
`define OP_STR  4'hC
`define OP_BEQ  4'hD
`define OP_JMP  4'hE
`endif

package hazard_unit_pkg;

  localparam int OP_W = `OP_CODE_LEN;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOP  = `OP_NOP;
  localparam op_t OP_ADD  = `OP_ADD;
  localparam op_t OP_SUB  = `OP_SUB;
  localparam op_t OP_MUL  = `OP_MUL;
  localparam op_t OP_DIV  = `OP_DIV;
  localparam op_t OP_MOD  = `OP_MOD;
  localparam op_t OP_AND  = `OP_AND;
  localparam op_t OP_OR   = `OP_OR;
  localparam op_t OP_CMP  = `OP_CMP;
  localparam op_t OP_MOVR = `OP_MOVR;
  localparam op_t OP_MOVI = `OP_MOVI;
  localparam op_t OP_LDR  = `OP_LDR;
  localparam op_t OP_STR  = `OP_STR;
  localparam op_t OP_BEQ  = `OP_BEQ;
  localparam op_t OP_JMP  = `OP_JMP;

  localparam int MDU_CYCLES_DEF = 4;
  localparam int SB_DEST_W      = 8;

  typedef struct packed {
    logic                 valid;
    logic [SB_DEST_W-1:0] dest;
    logic                 wb;
    logic                 ld;
    logic                 cmp;
  } sb_entry_t;

  function automatic logic uses_src1(input op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
      OP_AND, OP_OR, OP_CMP, OP_MOVR, OP_LDR,
      OP_STR:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_src2(input op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
      OP_AND, OP_OR, OP_CMP, OP_STR:
               return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_flags(input op_t op);
    return op == OP_BEQ;
  endfunction

  function automatic logic writes_reg(input op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
      OP_AND, OP_OR, OP_MOVR, OP_MOVI, OP_LDR:
               return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input op_t op);
    return op == OP_LDR;
  endfunction

  function automatic logic is_cmp(input op_t op);
    return op == OP_CMP;
  endfunction

  function automatic logic is_mdu(input op_t op);
    case (op)
      OP_MUL, OP_DIV, OP_MOD: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// EX/MEM producer mirror and multi-cycle busy counter.
// Priority: reset, flush, hold, bubble, advance.
module hazard_scoreboard
  import hazard_unit_pkg::*;
#(
  parameter int MDU_CYCLES = MDU_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_flush,
  input  logic      i_hold,
  input  logic      i_bubble,
  input  logic      i_mdu_start,
  input  sb_entry_t i_new,
  output sb_entry_t o_ex,
  output sb_entry_t o_mem,
  output logic      o_busy
);

  localparam int BW = (MDU_CYCLES > 1) ? $clog2(MDU_CYCLES) : 1;
  localparam logic [BW-1:0] BUSY_LOAD = BW'(MDU_CYCLES - 1);

  sb_entry_t     r_ex;
  sb_entry_t     r_mem;
  logic [BW-1:0] r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex   <= '0;
      r_mem  <= '0;
      r_busy <= '0;
    end else if (i_flush) begin
      r_ex   <= '0;
      r_mem  <= r_ex;
      r_busy <= '0;
    end else if (i_hold) begin
      r_mem  <= '0;
      r_busy <= r_busy - BW'(1);
    end else if (i_bubble) begin
      r_ex   <= '0;
      r_mem  <= r_ex;
    end else begin
      r_ex   <= i_new;
      r_mem  <= r_ex;
      if (i_mdu_start) r_busy <= BUSY_LOAD;
    end
  end

  assign o_ex   = r_ex;
  assign o_mem  = r_mem;
  assign o_busy = |r_busy;

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard detection: compares the ID instruction against
// in-flight EX/MEM producers and raises stall/flush strobes.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int MDU_CYCLES = MDU_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  op_t                   id_op,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  fwd_en,
  input  logic                  branch_taken,
  output logic                  hazard_detected,
  output logic                  pc_stall,
  output logic                  flush,
  output logic                  ex_busy
);

  logic                 w_u1;
  logic                 w_u2;
  logic                 w_uf;
  logic [SB_DEST_W-1:0] w_s1;
  logic [SB_DEST_W-1:0] w_s2;
  sb_entry_t            w_new;
  sb_entry_t            w_ex;
  sb_entry_t            w_mem;
  logic                 w_busy;
  logic                 w_src_ex;
  logic                 w_src_mem;
  logic                 w_flg_ex;
  logic                 w_flg_mem;
  logic                 w_raw;
  logic                 w_hz;

  function automatic logic srcmatch(
    input sb_entry_t            e,
    input logic                 u1,
    input logic                 u2,
    input logic [SB_DEST_W-1:0] s1,
    input logic [SB_DEST_W-1:0] s2
  );
    return e.valid & e.wb &
           ((u1 & (s1 == e.dest)) | (u2 & (s2 == e.dest)));
  endfunction

  assign w_u1 = uses_src1(id_op);
  assign w_u2 = uses_src2(id_op);
  assign w_uf = uses_flags(id_op);
  assign w_s1 = SB_DEST_W'(id_src1);
  assign w_s2 = SB_DEST_W'(id_src2);

  assign w_new = '{
    valid: id_valid,
    dest:  SB_DEST_W'(id_dest),
    wb:    writes_reg(id_op),
    ld:    is_load(id_op),
    cmp:   is_cmp(id_op)
  };

  assign w_src_ex  = srcmatch(w_ex, w_u1, w_u2, w_s1, w_s2);
  assign w_src_mem = srcmatch(w_mem, w_u1, w_u2, w_s1, w_s2);
  assign w_flg_ex  = w_ex.valid & w_ex.cmp & w_uf;
  assign w_flg_mem = w_mem.valid & w_mem.cmp & w_uf;

  // With forwarding only a load in EX cannot be bypassed in time.
  assign w_raw = fwd_en ? (w_src_ex & w_ex.ld)
                        : (w_src_ex | w_src_mem | w_flg_ex | w_flg_mem);

  always_comb begin
    w_hz = 1'b0;
    unique case (1'b1)
      branch_taken: w_hz = 1'b0;
      w_busy:       w_hz = 1'b1;
      default:      w_hz = id_valid & w_raw;
    endcase
  end

  hazard_scoreboard #(
    .MDU_CYCLES (MDU_CYCLES)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (branch_taken),
    .i_hold      (w_busy),
    .i_bubble    (w_hz),
    .i_mdu_start (id_valid & is_mdu(id_op)),
    .i_new       (w_new),
    .o_ex        (w_ex),
    .o_mem       (w_mem),
    .o_busy      (w_busy)
  );

  assign hazard_detected = ~rst & w_hz;
  assign pc_stall        = ~rst & w_hz;
  assign flush           = ~rst & branch_taken;
  assign ex_busy         = ~rst & w_busy;

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Produces the `hazard_detected` input consumed by the ID-stage controller, plus IF/ID freeze and flush strobes.
- Keeps a small registered scoreboard that mirrors the EX and MEM stages: destination, write-back, load and compare flags. It also has a busy counter for multi-cycle MUL/DIV/MOD.
- Sits beside the controller in ID and compares the incoming ID instruction against in-flight producers. With forwarding on, only load-use and multi-cycle stalls occur; with forwarding off, full RAW stalls occur.

Parameters:
- REG_ADDR_W, 4, register-address width.
- MDU_CYCLES, 4, EX occupancy of MUL/DIV/MOD in cycles; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- id_valid  in  1  ID holds a real instruction.
- id_op  in  `OP_CODE_LEN  ID opcode, encoded with the shared `OP_* values.
- id_src1  in  REG_ADDR_W  first source register.
- id_src2  in  REG_ADDR_W  second source register (STR data register).
- id_dest  in  REG_ADDR_W  destination register.
- fwd_en  in  1  forwarding unit active.
- branch_taken  in  1  EX resolved a taken BEQ or JMP.
- hazard_detected  out  1  to controller; bubble the current ID instruction.
- pc_stall  out  1  freeze PC and IF/ID.
- flush  out  1  clear IF/ID.
- ex_busy  out  1  multi-cycle op occupying EX.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Synchronous active-high reset rst.
  - On reset: ex/mem entries invalid, busy counter = 0.
  - All outputs are 0 during and after reset until inputs dictate otherwise.
- Opcode decode (shared package):
  - uses_src1: ADD, SUB, MUL, DIV, MOD, AND, OR, CMP, MOVR, LDR, STR.
  - uses_src2: ADD, SUB, MUL, DIV, MOD, AND, OR, CMP, STR.
  - uses_flags: BEQ.
  - writes_reg: ADD, SUB, MUL, DIV, MOD, AND, OR, MOVR, MOVI, LDR.
  - is_load: LDR.
  - is_cmp: CMP.
  - is_mdu: MUL, DIV, MOD.
  - Unknown opcodes use nothing and write nothing.
- Scoreboard entry: {valid, dest, wb, ld, cmp}. There are two entries, ex and mem.
- Register file writes before it reads in the same cycle, so the WB stage is not tracked.
- Combinational match:
  - srcmatch(e) = e.valid & e.wb & ((uses_src1 & id_src1==e.dest) | (uses_src2 & id_src2==e.dest)).
  - flagmatch(e) = e.valid & e.cmp & uses_flags.
- raw:
  - fwd_en=1: raw = srcmatch(ex) & ex.ld.
  - fwd_en=0: raw = srcmatch(ex) | srcmatch(mem) | flagmatch(ex) | flagmatch(mem).
- hazard_detected priority:
  - branch_taken → 0.
  - else busy≠0 → 1.
  - else id_valid & raw.
- Other outputs:
  - pc_stall = hazard_detected.
  - flush = branch_taken.
  - ex_busy = (busy≠0).
  - All outputs are combinational from registered state and the current inputs; no added latency.
- Per-cycle update, highest priority first:
  1. rst: clear as above.
  2. branch_taken: ex ← invalid (wrong-path ID is dropped), mem ← ex, busy ← 0.
  3. busy≠0: ex holds, mem ← invalid (bubble), busy ← busy−1.
  4. hazard_detected: ex ← invalid (bubble), mem ← ex.
  5. Otherwise:
     - ex ← {id_valid, id_dest, writes_reg, is_load, is_cmp}.
     - mem ← ex.
     - If id_valid & is_mdu: busy ← MDU_CYCLES−1.
- Multi-cycle ops:
  - An MDU op stalls the following ID instruction for exactly MDU_CYCLES−1 cycles.
  - MDU_CYCLES=1 gives no stall.
  - Back-to-back MDU ops each incur the full penalty.
- Mid-stall events:
  - branch_taken while busy≠0 cannot occur architecturally; if it does, branch_taken wins and the counter is cleared.
  - rst mid-stall or mid-busy clears everything in that cycle; there is no residual stall afterwards.
- Register R0 is not special.

Decomposition:
- Shared package holds:
  - the opcode-class decode functions;
  - the scoreboard entry struct;
  - the MDU_CYCLES default.
  - `OP_*` and `OP_CODE_LEN` come from the existing defines.
- One sub-module: hazard_scoreboard, holding the ex/mem entry registers and the busy counter, with advance/bubble/hold/flush controls.
- The match logic stays in hazard_unit.

Test Plan:
- Load-use with fwd_en=1:
  - Stimulus: LDR dest=3, then ADD src1=3.
  - Required: hazard_detected=1 and pc_stall=1 for exactly 1 cycle; ADD accepted next cycle.
  - Control: ADD src1=4 gives no stall.
- RAW with fwd_en=0:
  - Stimulus: ADD dest=5, then SUB src2=5.
  - Required: hazard 2 cycles.
  - Variant: a gap of one NOP gives a 1-cycle hazard.
  - Variant: CMP then BEQ gives a 2-cycle hazard.
- MDU with MDU_CYCLES=4:
  - Stimulus: DIV, then an independent OR.
  - Required: ex_busy=1 and hazard=1 for 3 cycles, then OR accepted.
  - Variant: MDU_CYCLES=1 gives no stall.
- Branch flush:
  - Stimulus: branch_taken=1 while ID holds LDR-dependent ADD.
  - Required: flush=1, hazard=0 that cycle; next cycle ex invalid; no stall follows.
- Reset mid-busy:
  - Stimulus: assert rst 1 cycle during an MDU stall with busy=2.
  - Required: next cycle all outputs 0; a dependent instruction issues without stall.
- Non-users:
  - Stimulus: MOVI or JMP after LDR dest=any, fwd_en=0.
  - Required: hazard=0.
  - Variant: STR src2 matching an LDR dest with fwd_en=1 gives a 1-cycle stall.
